// File: rtl/reg32_wr_arbiter.sv
// Round-robin write arbiter in front of a bank of REG32 registers, with
// optional locked bursts of up to four beats for a single requester.
module reg32_wr_arbiter #(
   parameter int NREQ   = 4,
   parameter int NREG   = 8,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [3*NREQ-1:0]        waddr,
   input  logic [DATA_W*NREQ-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREG-1:0]          CE,
   output logic [DATA_W-1:0]        D,
   output logic                     busy
);

   localparam int PW = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE_REQ = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [NREG-1:0] ONE_REG = {{(NREG-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state;
   logic [PW-1:0]     p;
   logic [PW-1:0]     owner;
   logic [1:0]        cnt;

   logic [2:0]        wa [NREQ];
   logic [DATA_W-1:0] wd [NREQ];

   logic              win_vld;
   logic [PW-1:0]     win;
   logic [PW-1:0]     idx;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign wa[i] = waddr[3*i +: 3];
      assign wd[i] = wdata[DATA_W*i +: DATA_W];
   end

   // Round-robin search starting at the pointer; first requester found wins.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = p + PW'(k);
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         p     <= '0;
         owner <= '0;
         cnt   <= '0;
         gnt   <= '0;
         CE    <= '0;
         D     <= '0;
         busy  <= 1'b0;
      end else begin
         gnt <= '0;
         CE  <= '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt <= ONE_REQ << win;
                  CE  <= ONE_REG << wa[win];
                  D   <= wd[win];
                  p   <= win + PW'(1);
                  if (lock[win]) begin
                     state <= LOCKED;
                     owner <= win;
                     cnt   <= 2'd1;
                     busy  <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               // Only the owner may write; the burst ends on the 4th beat,
               // on a beat without lock, or when the owner stops requesting.
               if (req[owner]) begin
                  gnt <= ONE_REQ << owner;
                  CE  <= ONE_REG << wa[owner];
                  D   <= wd[owner];
               end
               if (req[owner] && lock[owner] && cnt != 2'd3) begin
                  cnt <= cnt + 2'd1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  p     <= owner + PW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg32_wr_arbiter.sv
// Scoreboard bench for reg32_wr_arbiter: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a behavioural model.
module tb_reg32_wr_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req = '0;
   logic [3:0]   lock = '0;
   logic [11:0]  waddr = '0;
   logic [127:0] wdata = '0;
   logic [3:0]   gnt;
   logic [7:0]   CE;
   logic [31:0]  D;
   logic         busy;

   reg32_wr_arbiter #(.NREQ(4), .NREG(8), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .waddr(waddr),
      .wdata(wdata), .gnt(gnt), .CE(CE), .D(D), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  gnt;
      logic [7:0]  ce;
      logic [31:0] d;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model state
   int          ptr = 0;
   int          own = 0;
   int          beats = 0;
   bit          locked = 0;
   logic [31:0] last_d = '0;
   logic [31:0] mbank [8];
   logic [31:0] dut_bank [8];

   initial for (int i = 0; i < 8; i++) begin
      mbank[i] = '0;
      dut_bank[i] = '0;
   end

   // The bank captures D on the edge after CE is presented.
   always @(posedge clk)
      for (int i = 0; i < 8; i++)
         if (CE[i] === 1'b1) dut_bank[i] <= D;

   task automatic model_push();
      exp_t e;
      int w;
      int a;
      e = '0;
      w = -1;
      if (rst) begin
         ptr = 0; locked = 0; own = 0; beats = 0; last_d = '0;
      end else begin
         if (locked) begin
            if (req[own]) begin
               w = own;
               beats++;
               if (!(lock[own] && beats < 4)) begin
                  locked = 0;
                  ptr = (own + 1) % 4;
               end
            end else begin
               locked = 0;
               ptr = (own + 1) % 4;
            end
         end else begin
            for (int k = 0; k < 4; k++)
               if (w < 0 && req[(ptr + k) % 4]) w = (ptr + k) % 4;
            if (w >= 0) begin
               ptr = (w + 1) % 4;
               if (lock[w]) begin
                  locked = 1; own = w; beats = 1;
               end
            end
         end
         if (w >= 0) begin
            a = int'(waddr[3*w +: 3]);
            e.gnt = 4'b0001 << w;
            e.ce = 8'b0000_0001 << a;
            last_d = wdata[32*w +: 32];
            mbank[a] = last_d;
         end
      end
      e.d = last_d;
      e.busy = locked;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic [11:0] wa, input logic [127:0] wd);
      @(negedge clk);
      rst = r; req = rq; lock = lk; waddr = wa; wdata = wd;
      model_push();
   endtask

   function automatic logic [11:0] pa(input int a0, a1, a2, a3);
      return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   function automatic logic [127:0] pd(input logic [31:0] d0, d1, d2, d3);
      return {d3, d2, d1, d0};
   endfunction

   // Monitor: one expected response per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({gnt, CE, D, busy} !== e) begin
               errors++;
               $display("FAIL cycle_out t=%0t got gnt=%b CE=%b D=%h busy=%b expected gnt=%b CE=%b D=%h busy=%b",
                        $time, gnt, CE, D, busy, e.gnt, e.ce, e.d, e.busy);
            end
         end
      end
   end

   initial begin
      logic [11:0]  wa;
      logic [127:0] wd;

      repeat (2) drive(1, 4'b0000, 4'b0000, '0, '0);

      // Alternating pair
      wa = pa(3, 0, 5, 0);
      wd = pd(32'd1, 32'd0, 32'd2, 32'd0);
      repeat (5) drive(0, 4'b0101, 4'b0000, wa, wd);

      // All four requesting, no lock
      wa = pa(1, 2, 4, 6);
      wd = pd(32'h10, 32'h11, 32'h12, 32'h13);
      drive(1, 4'b0000, 4'b0000, wa, wd);
      repeat (8) drive(0, 4'b1111, 4'b0000, wa, wd);

      // Locked burst by requester 1 while requester 0 waits
      drive(1, 4'b0000, 4'b0000, wa, wd);
      drive(0, 4'b0001, 4'b0000, wa, wd);
      repeat (6) drive(0, 4'b0011, 4'b0010, wa, wd);

      // Requester 2 locks then drops after two beats; 3 is waiting
      drive(1, 4'b0000, 4'b0000, wa, wd);
      drive(0, 4'b0010, 4'b0000, wa, wd);
      repeat (2) drive(0, 4'b1100, 4'b0100, wa, wd);
      repeat (3) drive(0, 4'b1000, 4'b0000, wa, wd);

      // Reset in the middle of a burst with requests held
      drive(1, 4'b0000, 4'b0000, wa, wd);
      repeat (2) drive(0, 4'b0011, 4'b0011, wa, wd);
      drive(1, 4'b0011, 4'b0011, wa, wd);
      repeat (3) drive(0, 4'b0011, 4'b0011, wa, wd);

      // Two requesters writing the same register
      drive(1, 4'b0000, 4'b0000, wa, wd);
      wa = pa(7, 0, 0, 7);
      wd = pd(32'hA, 32'h0, 32'h0, 32'hB);
      drive(0, 4'b1001, 4'b0000, wa, wd);
      drive(0, 4'b1000, 4'b0000, wa, wd);
      repeat (2) drive(0, 4'b0000, 4'b0000, wa, wd);
      checks++;
      if (dut_bank[7] !== 32'hB) begin
         errors++;
         $display("FAIL same_addr_last_write got %h expected %h", dut_bank[7], 32'hB);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic r;
         logic [3:0] rq, lk;
         r  = ($urandom_range(0, 60) == 0);
         rq = 4'($urandom);
         lk = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
         wd = {$urandom, $urandom, $urandom, $urandom};
         drive(r, rq, lk, 12'($urandom), wd);
      end
      drive(0, 4'b0000, 4'b0000, '0, '0);
      @(posedge clk);
      @(posedge clk);
      #2;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut_bank[i] !== mbank[i]) begin
            errors++;
            $display("FAIL bank_reg%0d got %h expected %h", i, dut_bank[i], mbank[i]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
